// File: rtl/regs_wb.sv
// regs_wb: integer register file (x0..x31) and pipeline writeback endpoint.
// A single shared write port serves pipeline writeback, which always wins, and
// a debug request/acknowledge channel. A debug write that keeps losing the
// port raises dbg_hold_o so the controller can stall writeback.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   reg1/reg2_raddr_i, _rdata_o  decode read ports (combinational, write-through bypass)
//   rd_addr_i/rd_data_i/rd_wen_i writeback triple from execute
//   dbg_req_i/we_i/addr_i/wdata_i debug request (level, held until ack)
//   dbg_rdata_o, dbg_ack_o     registered debug read data and one-cycle ack
//   dbg_hold_o                 registered writeback stall request
module regs_wb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg1_raddr_i,
    input  logic [4:0]  reg2_raddr_i,
    output logic [31:0] reg1_rdata_o,
    output logic [31:0] reg2_rdata_o,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_ack_o,
    output logic        dbg_hold_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } dbg_state_t;

    logic [XLEN-1:0]  regs [NREGS];
    dbg_state_t       state;
    logic [CNT_W-1:0] starve_cnt;

    logic             pipe_wr;
    logic             dbg_wr_go;
    logic [XLEN-1:0]  dbg_rd_val;
    logic [CNT_W-1:0] starve_inc;

    // Pipeline writes to x0 are dropped here so x0 storage stays zero.
    assign pipe_wr = rd_wen_i && (rd_addr_i != AW'(0));

    // Debug write performs only on cycles the pipeline leaves the port idle.
    assign dbg_wr_go = !rd_wen_i &&
                       (((state == IDLE) && dbg_req_i && dbg_we_i) || (state == PEND));

    assign starve_inc = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_ONE;

    // Read ports: zero during reset and for x0, same-cycle writeback bypassed.
    assign reg1_rdata_o = (rst || (reg1_raddr_i == AW'(0))) ? XLEN'(0) :
                          (rd_wen_i && (rd_addr_i == reg1_raddr_i)) ? rd_data_i :
                          regs[reg1_raddr_i];

    assign reg2_rdata_o = (rst || (reg2_raddr_i == AW'(0))) ? XLEN'(0) :
                          (rd_wen_i && (rd_addr_i == reg2_raddr_i)) ? rd_data_i :
                          regs[reg2_raddr_i];

    // Debug read sees the same bypass so a colliding writeback returns new data.
    assign dbg_rd_val = (dbg_addr_i == AW'(0)) ? XLEN'(0) :
                        (rd_wen_i && (rd_addr_i == dbg_addr_i)) ? rd_data_i :
                        regs[dbg_addr_i];

    // Register file write port, debug FSM and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            state       <= IDLE;
            starve_cnt  <= '0;
            dbg_ack_o   <= 1'b0;
            dbg_hold_o  <= 1'b0;
            dbg_rdata_o <= '0;
        end else begin
            dbg_ack_o  <= 1'b0;
            dbg_hold_o <= 1'b0;

            if (pipe_wr) begin
                regs[rd_addr_i] <= rd_data_i;
            end else if (dbg_wr_go && (dbg_addr_i != AW'(0))) begin
                regs[dbg_addr_i] <= dbg_wdata_i;
            end

            case (state)
                IDLE: begin
                    if (dbg_req_i) begin
                        if (!dbg_we_i) begin
                            dbg_rdata_o <= dbg_rd_val;
                            state       <= ACK;
                            dbg_ack_o   <= 1'b1;
                        end else if (!rd_wen_i) begin
                            state     <= ACK;
                            dbg_ack_o <= 1'b1;
                        end else begin
                            state      <= PEND;
                            starve_cnt <= CNT_ONE;
                            dbg_hold_o <= (CNT_ONE >= LIMIT_CNT);
                        end
                    end
                end
                PEND: begin
                    if (!rd_wen_i) begin
                        state      <= ACK;
                        dbg_ack_o  <= 1'b1;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= starve_inc;
                        dbg_hold_o <= (starve_inc >= LIMIT_CNT);
                    end
                end
                ACK: begin
                    state <= REL;
                end
                REL: begin
                    // A still-held request is ignored until it drops.
                    if (!dbg_req_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regs_wb.sv
// tb_regs_wb: directed self-checking bench for regs_wb (STARVE_LIMIT = 4).
module tb_regs_wb;

    logic        clk;
    logic        rst;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o;
    logic        dbg_hold_o;

    int total;
    int bad;

    regs_wb #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg1_raddr_i (reg1_raddr_i),
        .reg2_raddr_i (reg2_raddr_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_rdata_o (reg2_rdata_o),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .rd_wen_i     (rd_wen_i),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_rdata_o  (dbg_rdata_o),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_hold_o   (dbg_hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        reg1_raddr_i = '0; reg2_raddr_i = '0;
        rd_addr_i = '0; rd_data_i = '0; rd_wen_i = 1'b0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;

        // Reset then read
        tick();
        tick();
        chk("rst_ack", 32'(dbg_ack_o), 32'd0);
        chk("rst_rdata", dbg_rdata_o, 32'd0);
        rst = 1'b0;
        reg1_raddr_i = 5'd5;
        #1;
        chk("rst_read5", reg1_rdata_o, 32'd0);
        chk("rst_hold", 32'(dbg_hold_o), 32'd0);

        // Write-through bypass, then stored value
        rd_wen_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'hDEADBEEF;
        reg1_raddr_i = 5'd3; reg2_raddr_i = 5'd4;
        #1;
        chk("bypass_p1", reg1_rdata_o, 32'hDEADBEEF);
        chk("nobypass_p2", reg2_rdata_o, 32'd0);
        tick();
        rd_wen_i = 1'b0;
        #1;
        chk("stored_x3", reg1_rdata_o, 32'hDEADBEEF);

        // x0 is never written and always reads zero
        rd_wen_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'h1234; reg2_raddr_i = 5'd0;
        #1;
        chk("x0_bypass", reg2_rdata_o, 32'd0);
        tick();
        rd_wen_i = 1'b0;
        #1;
        chk("x0_after", reg2_rdata_o, 32'd0);

        // Uncontended debug write: ack right after the perform edge, only once
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'h55AA55AA;
        reg1_raddr_i = 5'd7;
        #1;
        chk("dw_pre_ack", 32'(dbg_ack_o), 32'd0);
        tick();
        chk("dw_ack", 32'(dbg_ack_o), 32'd1);
        chk("dw_x7", reg1_rdata_o, 32'h55AA55AA);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("dw_noack%0d", k), 32'(dbg_ack_o), 32'd0);
        end
        dbg_req_i = 1'b0;
        tick();

        // Starvation: debug write to x9 deferred six cycles by writeback to x10
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h99990001;
        rd_wen_i = 1'b1; rd_addr_i = 5'd10; rd_data_i = 32'h10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("st_ack%0d", k), 32'(dbg_ack_o), 32'd0);
            chk($sformatf("st_hold%0d", k), 32'(dbg_hold_o), (k >= 4) ? 32'd1 : 32'd0);
        end
        rd_wen_i = 1'b0;
        reg1_raddr_i = 5'd9; reg2_raddr_i = 5'd10;
        #1;
        chk("st_x9_pending", reg1_rdata_o, 32'd0);
        tick();
        chk("st_ack", 32'(dbg_ack_o), 32'd1);
        chk("st_hold_fall", 32'(dbg_hold_o), 32'd0);
        chk("st_x9", reg1_rdata_o, 32'h99990001);
        chk("st_x10", reg2_rdata_o, 32'h10);
        dbg_req_i = 1'b0;
        tick();
        tick();

        // Debug read colliding with a writeback to the same register
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
        rd_wen_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'h77;
        tick();
        chk("dr_coll_ack", 32'(dbg_ack_o), 32'd1);
        chk("dr_coll_data", dbg_rdata_o, 32'h77);
        rd_wen_i = 1'b0; dbg_req_i = 1'b0;
        tick();
        tick();
        chk("dr_data_held", dbg_rdata_o, 32'h77);

        // Uncontended debug read of x7
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd7;
        tick();
        chk("dr_x7_ack", 32'(dbg_ack_o), 32'd1);
        chk("dr_x7_data", dbg_rdata_o, 32'h55AA55AA);
        dbg_req_i = 1'b0;
        tick();
        tick();

        // Reset while a debug write is pending abandons it
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd12; dbg_wdata_i = 32'hCAFE;
        rd_wen_i = 1'b1; rd_addr_i = 5'd13; rd_data_i = 32'h13;
        tick();
        tick();
        rst = 1'b1; rd_wen_i = 1'b0; reg1_raddr_i = 5'd3;
        #1;
        chk("abort_read_in_rst", reg1_rdata_o, 32'd0);
        tick();
        chk("abort_ack", 32'(dbg_ack_o), 32'd0);
        chk("abort_hold", 32'(dbg_hold_o), 32'd0);
        chk("abort_rdata", dbg_rdata_o, 32'd0);
        dbg_req_i = 1'b0;
        rst = 1'b0;
        reg1_raddr_i = 5'd3; reg2_raddr_i = 5'd7;
        #1;
        chk("abort_x3_clr", reg1_rdata_o, 32'd0);
        chk("abort_x7_clr", reg2_rdata_o, 32'd0);
        reg1_raddr_i = 5'd12; reg2_raddr_i = 5'd13;
        tick();
        chk("abort_x12", reg1_rdata_o, 32'd0);
        chk("abort_x13", reg2_rdata_o, 32'd0);
        chk("abort_noack", 32'(dbg_ack_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
